// File: rtl/seq_detect_ctrl.sv
// Word-level controller for an external overlapping "1101" Mealy detector: serialises
// each accepted word into the detector, collects its matches and reports a per-word result.
module seq_detect_ctrl #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TOT_W     = 16,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              det_in,
  output logic              det_rst_n,
  input  logic              det_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  m_count,
  output logic [CNT_W-1:0]  m_first,
  output logic              m_hit,
  output logic [TOT_W-1:0]  tot_count,
  input  logic              tot_clr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, REPORT} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  state_t            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [CNT_W-1:0]  bit_q;
  logic              det_in_q;
  logic              det_rst_n_q;
  logic              m_valid_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  first_q;
  logic              hit_q;
  logic [TOT_W-1:0]  tot_q;
  logic [TOT_W-1:0]  tot_d;
  logic              head_bit;
  logic [WORD_W-1:0] sreg_shift;
  logic              match;

  always_comb begin
    head_bit   = (LSB_FIRST != 0) ? sreg_q[0] : sreg_q[WORD_W-1];
    sreg_shift = (LSB_FIRST != 0) ? (sreg_q >> 1) : (sreg_q << 1);
    match      = (state_q == SHIFT) && det_out;
    // Clear has priority over a coincident increment.
    tot_d = tot_q;
    if (tot_clr)
      tot_d = '0;
    else if (match && (tot_q != {TOT_W{1'b1}}))
      tot_d = tot_q + TOT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_q       <= '0;
      det_in_q    <= 1'b0;
      det_rst_n_q <= 1'b0;
      m_valid_q   <= 1'b0;
      count_q     <= '0;
      first_q     <= '0;
      hit_q       <= 1'b0;
      tot_q       <= '0;
    end else begin
      tot_q <= tot_d;
      case (state_q)
        IDLE: begin
          det_rst_n_q <= 1'b1;
          if (s_valid) begin
            sreg_q      <= s_data;
            bit_q       <= '0;
            count_q     <= '0;
            first_q     <= '0;
            hit_q       <= 1'b0;
            det_rst_n_q <= 1'b0;
            state_q     <= FLUSH;
          end
        end
        FLUSH: begin
          // Bit 0 is presented as SHIFT begins, after the detector has been cleared.
          det_rst_n_q <= 1'b1;
          det_in_q    <= head_bit;
          sreg_q      <= sreg_shift;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          if (det_out) begin
            count_q <= count_q + CNT_W'(1);
            if (!hit_q) begin
              first_q <= bit_q;
              hit_q   <= 1'b1;
            end
          end
          if (bit_q == LAST_BIT) begin
            det_in_q  <= 1'b0;
            m_valid_q <= 1'b1;
            state_q   <= REPORT;
          end else begin
            bit_q    <= bit_q + CNT_W'(1);
            det_in_q <= head_bit;
            sreg_q   <= sreg_shift;
          end
        end
        REPORT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign det_in    = det_in_q;
  assign det_rst_n = det_rst_n_q;
  assign m_valid   = m_valid_q;
  assign m_count   = count_q;
  assign m_first   = first_q;
  assign m_hit     = hit_q;
  assign tot_count = tot_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: two instances (MSB-first/16-bit total, LSB-first/3-bit total),
// each driving a string-matching model of the "1101" detector, checked against a word-level model.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] s_valid, s_ready, det_in, det_rst_n, det_out;
  logic [1:0] m_valid, m_ready, m_hit, tot_clr, busy;
  logic [7:0] s_data  [2];
  logic [3:0] m_count [2];
  logic [3:0] m_first [2];
  logic [15:0] tot0;
  logic [2:0]  tot1;

  int nvec = 0;
  int nerr = 0;
  int exp_tot [2];

  seq_detect_ctrl #(.WORD_W(8), .CNT_W(4), .TOT_W(16), .LSB_FIRST(0)) u0 (
    .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .det_in(det_in[0]), .det_rst_n(det_rst_n[0]), .det_out(det_out[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_count(m_count[0]), .m_first(m_first[0]),
    .m_hit(m_hit[0]), .tot_count(tot0), .tot_clr(tot_clr[0]), .busy(busy[0])
  );

  // Narrow total so saturation and clear-vs-increment are reachable in a short run.
  seq_detect_ctrl #(.WORD_W(8), .CNT_W(4), .TOT_W(3), .LSB_FIRST(1)) u1 (
    .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .det_in(det_in[1]), .det_rst_n(det_rst_n[1]), .det_out(det_out[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_count(m_count[1]), .m_first(m_first[1]),
    .m_hit(m_hit[1]), .tot_count(tot1), .tot_clr(tot_clr[1]), .busy(busy[1])
  );

  // Detector model: match when the last three bits since clear were 110 and the current bit is 1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_det
    logic [2:0] hist;
    logic [1:0] nb;
    always_ff @(posedge clk) begin
      if (!det_rst_n[gi]) begin
        hist <= 3'b000;
        nb   <= 2'd0;
      end else begin
        hist <= {hist[1:0], det_in[gi]};
        if (nb != 2'd3) nb <= nb + 2'd1;
      end
    end
    assign det_out[gi] = det_in[gi] && (hist == 3'b110) && (nb == 2'd3);
  end

  function automatic int tot_max(input int i);
    return (i == 0) ? 65535 : 7;
  endfunction

  function automatic logic [31:0] get_tot(input int i);
    return (i == 0) ? 32'(tot0) : 32'(tot1);
  endfunction

  function automatic void ref_model(input logic [7:0] w, input int lsb,
                                    output int cnt, output int first);
    logic b [8];
    for (int k = 0; k < 8; k++) b[k] = (lsb != 0) ? w[k] : w[7-k];
    cnt = 0;
    first = 0;
    for (int k = 3; k < 8; k++) begin
      if (b[k-3] && b[k-2] && !b[k-1] && b[k]) begin
        if (cnt == 0) first = k;
        cnt++;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] w, input int hold, input bit clr);
    int cnt, first, lat, wt, dlow, first_low;
    bit cleared;
    ref_model(w, i, cnt, first);
    wt = 0;
    @(negedge clk);
    while (!s_ready[i] && wt < 50) begin @(negedge clk); wt++; end
    chk("s_ready_wait", 32'(s_ready[i]), 32'd1);
    s_valid[i] = 1'b1;
    s_data[i]  = w;
    @(posedge clk); #1;
    s_valid[i] = 1'b0;
    s_data[i]  = 8'($urandom);
    chk("accept_busy", 32'(busy[i]), 32'd1);
    chk("accept_sready", 32'(s_ready[i]), 32'd0);
    lat = 0; dlow = 0; first_low = 0; cleared = 1'b0;
    while (!m_valid[i] && lat < 40) begin
      if (!det_rst_n[i]) dlow++;
      if (lat == 0) first_low = det_rst_n[i] ? 0 : 1;
      tot_clr[i] = clr && !cleared && det_out[i];
      @(posedge clk); #1;
      lat++;
      if (tot_clr[i]) begin
        chk("clr_wins", get_tot(i), 32'd0);
        cleared = 1'b1;
        tot_clr[i] = 1'b0;
      end
    end
    // Accept in cycle T, sampling starts in T+1, so the cycle of m_valid is 1+lat.
    chk("latency", 32'(1 + lat), 32'd10);
    chk("flush_first_cycle", 32'(first_low), 32'd1);
    chk("flush_len", 32'(dlow), 32'd1);
    if (cleared) exp_tot[i] = cnt - 1;
    else exp_tot[i] = (exp_tot[i] + cnt > tot_max(i)) ? tot_max(i) : exp_tot[i] + cnt;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(m_valid[i]), 32'd1);
      chk("bp_count", 32'(m_count[i]), 32'(cnt));
      chk("bp_first", 32'(m_first[i]), 32'(first));
      chk("bp_sready", 32'(s_ready[i]), 32'd0);
    end
    chk("m_count", 32'(m_count[i]), 32'(cnt));
    chk("m_first", 32'(m_first[i]), 32'(first));
    chk("m_hit", 32'(m_hit[i]), (cnt > 0) ? 32'd1 : 32'd0);
    chk("tot_count", get_tot(i), 32'(exp_tot[i]));
    $display("word inst=%0d data=%02h count=%0d first=%0d hit=%0d tot=%0d hold=%0d",
             i, w, m_count[i], m_first[i], m_hit[i], get_tot(i), hold);
    @(negedge clk);
    m_ready[i] = 1'b1;
    @(posedge clk); #1;
    m_ready[i] = 1'b0;
    chk("release_valid", 32'(m_valid[i]), 32'd0);
    chk("release_sready", 32'(s_ready[i]), 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    s_valid = '0; m_ready = '0; tot_clr = '0;
    s_data[0] = '0; s_data[1] = '0;
    exp_tot[0] = 0; exp_tot[1] = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sready", 32'(s_ready[i]), 32'd1);
      chk("rst_mvalid", 32'(m_valid[i]), 32'd0);
      chk("rst_detrst", 32'(det_rst_n[i]), 32'd0);
      chk("rst_detin", 32'(det_in[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_count", 32'(m_count[i]), 32'd0);
      chk("rst_tot", get_tot(i), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    send(0, 8'b1101_1010, 0, 1'b0);
    send(0, 8'b1101_1101, 0, 1'b0);
    send(0, 8'hFF, 0, 1'b0);
    send(1, 8'h0B, 0, 1'b0);
    send(0, 8'b1101_1010, 5, 1'b0);

    // Reset while u0 is shifting bit 4; bit 3 already matched.
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'b1101_1010;
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy[0]), 32'd1);
    chk("mid_tot", get_tot(0), 32'(exp_tot[0] + 1));
    reset = 1'b0;
    #1;
    chk("mid_rst_mvalid", 32'(m_valid[0]), 32'd0);
    chk("mid_rst_sready", 32'(s_ready[0]), 32'd1);
    chk("mid_rst_tot", get_tot(0), 32'd0);
    chk("mid_rst_detin", 32'(det_in[0]), 32'd0);
    exp_tot[0] = 0; exp_tot[1] = 0;
    @(negedge clk);
    reset = 1'b1;
    send(0, 8'b1101_0000, 0, 1'b0);

    // Saturation of the 3-bit total, then clear coinciding with a match.
    repeat (5) send(1, 8'b1101_1011, 0, 1'b0);
    send(1, 8'b1101_1011, 0, 1'b1);

    for (int n = 0; n < 30; n++)
      send(int'($urandom_range(1, 0)), 8'($urandom), int'($urandom_range(3, 0)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
